// File: rtl/mem_bus_master.sv
// Bus initiator that turns 16-bit load/store requests into read-strobe word
// captures and one or two clocked byte writes on the byte-write/word-read memory port.
module mem_bus_master #(
    parameter int READ_WAIT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_byte,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic [7:0]  mem_din,
    output logic [15:0] mem_addr,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [15:0] mem_dout
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR_LO,
        WR_HI,
        RESP
    } state_t;

    state_t      state;
    logic [3:0]  wait_cnt;
    logic [7:0]  hi_byte;
    logic        is_byte;
    logic        read_q;
    logic        write_q;

    // Request fields are captured at acceptance; the high byte waits in hi_byte for WR_HI.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            hi_byte   <= '0;
            is_byte   <= 1'b0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            mem_din   <= '0;
            mem_addr  <= '0;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        mem_addr  <= req_addr;
                        if (req_write) begin
                            state   <= WR_LO;
                            mem_din <= req_wdata[7:0];
                            hi_byte <= req_wdata[15:8];
                            is_byte <= req_byte;
                            write_q <= 1'b1;
                        end else begin
                            state    <= RD;
                            wait_cnt <= 4'(READ_WAIT - 1);
                            read_q   <= 1'b1;
                        end
                    end
                end
                RD: begin
                    if (wait_cnt == 4'd0) begin
                        rsp_rdata <= mem_dout;
                        read_q    <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                WR_LO: begin
                    if (is_byte) begin
                        write_q   <= 1'b0;
                        mem_din   <= '0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        mem_addr <= mem_addr + 16'd1;
                        mem_din  <= hi_byte;
                        state    <= WR_HI;
                    end
                end
                WR_HI: begin
                    write_q   <= 1'b0;
                    mem_din   <= '0;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes are masked by reset so an aborted store cannot write its pending byte
    // on the very edge that resets the block.
    assign mem_read  = read_q  & ~rst;
    assign mem_write = write_q & ~rst;

endmodule
